// File: rtl/instr_pkg.sv
// instr_pkg: definitions shared by the RV32I instruction encoder and decoder.
//   fmt_e        - instruction format selector (R,I,S,B,U,J)
//   OP_*         - commonly used major opcodes
//   IMM_*_MIN/MAX- legal signed immediate ranges per format
//   bswap32      - instruction word to little-endian memory byte order
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  // I and S share the 12-bit signed range.
  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX =  32'sd2047;
  // B and J offsets are even; max is the largest even value.
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX  =  32'sd1048574;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field-to-word packing for RV32I plus legality check.
//   fmt_i    - format (fmt_e encoding)
//   opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i - instruction fields
//   imm_i    - full 32-bit signed immediate (byte offset / value)
//   word_o   - packed instruction word (bit order as in the ISA, not memory)
//   err_o    - bundle is illegal (immediate out of range / misaligned,
//              bad opcode low bits, or unknown format)
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic signed [31:0] w_simm;
  assign w_simm = $signed(imm_i);

  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o  = (w_simm < IMM_IS_MIN) || (w_simm > IMM_IS_MAX);
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o  = (w_simm < IMM_IS_MIN) || (w_simm > IMM_IS_MAX);
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        err_o  = imm_i[0] || (w_simm < IMM_B_MIN) || (w_simm > IMM_B_MAX);
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        // U carries only the upper 20 bits; any low bits would be lost.
        err_o  = (imm_i[11:0] != 12'd0);
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o  = imm_i[0] || (w_simm < IMM_J_MIN) || (w_simm > IMM_J_MAX);
      end
      default: err_o = 1'b1;
    endcase
    if (opcode_i[1:0] != 2'b11) err_o = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into words and streams them, byte-swapped
// to little-endian memory order, to instruction memory at an auto-incrementing
// word address. Two-stage valid/ready pipeline: s1 = encode, s2 = write.
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   in_valid_i / in_ready_o      - field bundle handshake
//   fmt_i..imm_i                 - instruction fields
//   addr_load_i / addr_i         - load word address counter
//   mem_we_o / mem_ready_i       - memory write handshake
//   mem_addr_o / mem_data_o      - write address (counter) and swapped word
//   err_o                        - one-cycle pulse when an illegal bundle drops
//   count_o                      - words written since reset (wraps)
module instr_encoder
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  input  logic              addr_load_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [31:0]       w_word;
  logic              w_err;
  logic              w_s2_adv, w_s1_adv, w_in_xfer, w_wr_xfer, w_s1_to_s2;

  logic              r_s1_valid, r_s1_err;
  logic [31:0]       r_s1_word;
  logic              r_s2_valid;
  logic [31:0]       r_s2_data;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;

  instr_pack u_pack (
    .fmt_i   (fmt_i),
    .opcode_i(opcode_i),
    .funct3_i(funct3_i),
    .funct7_i(funct7_i),
    .rd_i    (rd_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .imm_i   (imm_i),
    .word_o  (w_word),
    .err_o   (w_err)
  );

  // An errored s1 entry drains without waiting on s2, so a stalled memory
  // never blocks the error pulse.
  assign w_s2_adv   = !r_s2_valid || mem_ready_i;
  assign w_s1_adv   = r_s1_valid && (r_s1_err || w_s2_adv);
  assign w_s1_to_s2 = w_s1_adv && !r_s1_err;
  assign in_ready_o = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid_i && in_ready_o;
  assign w_wr_xfer  = r_s2_valid && mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_word  <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= w_err;
      r_s1_word  <= w_word;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_s1_adv && r_s1_err;
      if (w_s2_adv) r_s2_valid <= w_s1_to_s2;
      // Data only changes when a new word enters; held through stalls and idle.
      if (w_s1_to_s2) r_s2_data <= bswap32(r_s1_word);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else begin
      // Load beats a coincident write; that write already used the old address.
      if (addr_load_i)    r_addr <= addr_i & ~ADDR_W'(3);
      else if (w_wr_xfer) r_addr <= r_addr + ADDR_W'(4);
      if (w_wr_xfer) r_count <= r_count + CNT_W'(1);
    end
  end

  assign mem_we_o   = r_s2_valid;
  assign mem_data_o = r_s2_data;
  assign mem_addr_o = r_addr;
  assign err_o      = r_err;
  assign count_o    = r_count;

endmodule
